// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM states, instruction field positions and ALU select codes
package alu_pkg;
    typedef enum logic [2:0] {IDLE, OPER, EXEC, WB, ERR} state_t;
    localparam logic [1:0] LOGIC_CLASS = 2'b01;
    localparam int CLS_LSB = 6;
    localparam int SEL_LSB = 4;
    localparam int RD_LSB = 2;
    localparam int RS_LSB = 0;
    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;
    localparam logic [1:0] SEL_ANDN = 2'b11;
    function automatic logic is_logic(input logic [7:0] instr);
        return instr[CLS_LSB+:2] == LOGIC_CLASS;
    endfunction
endpackage

// File: rtl/alu_regfile4.sv
// alu_regfile4: 4-entry register file, one write port (writeback beats load), two operand reads and a debug read
module alu_regfile4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [1:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [1:0]       ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [1:0]       rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    logic [WIDTH-1:0] mem_q [4];
    logic [WIDTH-1:0] mem_d [4];
    always_comb begin
        for (int i = 0; i < 4; i++)
            mem_d[i] = (wb_en && wb_addr == 2'(i)) ? wb_data :
                       (ld_en && ld_addr == 2'(i)) ? ld_data : mem_q[i];
    end
    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        else
            mem_q <= mem_d;
    end
    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];
    assign dbg_data = mem_q[dbg_addr];
endmodule

// File: rtl/alu_logic_issue.sv
// alu_logic_issue: issue/writeback stage driving an external logic ALU from a 4-entry register file
// ports: instr_valid/instr_ready/instr handshake in; alu_a/alu_b/alu_s out, alu_out in;
//        ld_* external register load; dbg_addr/dbg_data debug read; done/illegal pulses; flag_z/flag_n
module alu_logic_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             done,
    output logic             illegal,
    output logic             flag_z,
    output logic             flag_n
);
    state_t state_q, state_d;
    logic [5:0] instr_q, instr_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
    logic [1:0] alu_s_q, alu_s_d;
    logic flag_z_q, flag_z_d, flag_n_q, flag_n_d, done_q, done_d, illegal_q, illegal_d;
    logic hs, legal;
    logic [1:0] rd, rs;
    logic [WIDTH-1:0] rf_a, rf_b;
    assign rd = instr_q[RD_LSB+:2];
    assign rs = instr_q[RS_LSB+:2];
    alu_regfile4 #(.WIDTH(WIDTH)) u_rf (
        .clk(clk), .rst(rst),
        .wb_en(state_q == WB), .wb_addr(rd), .wb_data(result_q),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ra_addr(rd), .ra_data(rf_a),
        .rb_addr(rs), .rb_data(rf_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );
    always_comb begin
        legal = is_logic(instr);
        hs = state_q == IDLE && instr_valid;
        state_d = state_q == IDLE ? (instr_valid ? (legal ? OPER : ERR) : IDLE) :
                  state_q == OPER ? EXEC :
                  state_q == EXEC ? WB : IDLE;
        instr_d = hs ? instr[5:0] : instr_q;
        alu_a_d = state_q == OPER ? rf_a : alu_a_q;
        alu_b_d = state_q == OPER ? rf_b : alu_b_q;
        alu_s_d = state_q == OPER ? instr_q[SEL_LSB+:2] : alu_s_q;
        result_d = state_q == EXEC ? alu_out : result_q;
        flag_z_d = state_q == WB ? result_q == '0 : flag_z_q;
        flag_n_d = state_q == WB ? result_q[WIDTH-1] : flag_n_q;
        // pulses are registered so they coincide with the WB / ERR cycles
        done_d = state_q == EXEC;
        illegal_d = hs && !legal;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_s_q <= '0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            done_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            alu_s_q <= alu_s_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            done_q <= done_d;
            illegal_q <= illegal_d;
        end
    end
    assign instr_ready = state_q == IDLE;
    assign alu_a = alu_a_q;
    assign alu_b = alu_b_q;
    assign alu_s = alu_s_q;
    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign done = done_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_alu_logic_issue.sv
// tb_alu_logic_issue: randomized scoreboard bench for the logic-ALU issue stage
module tb_alu_logic_issue;
    import alu_pkg::*;
    localparam int W = 8;
    logic clk, rst, instr_valid, instr_ready, ld_en, done, illegal, flag_z, flag_n;
    logic [7:0] instr;
    logic [W-1:0] alu_a, alu_b, alu_out, ld_data, dbg_data;
    logic [1:0] alu_s, ld_addr, dbg_addr;

    alu_logic_issue #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .done(done), .illegal(illegal), .flag_z(flag_z), .flag_n(flag_n)
    );

    always_comb
        alu_out = alu_s == SEL_AND ? (alu_a & alu_b) :
                  alu_s == SEL_OR  ? (alu_a | alu_b) :
                  alu_s == SEL_XOR ? (alu_a ^ alu_b) : (alu_a & ~alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0, fails = 0;
    typedef struct {bit ill; logic [1:0] rd; logic [7:0] val; bit z; bit n; int at;} exp_t;
    typedef struct {logic [1:0] a; logic [7:0] v;} chk_t;
    exp_t exp_q[$];
    chk_t chk_q[$];
    logic [7:0] m [4];
    bit mz, mn;
    int g_end = -10;
    logic [1:0] g_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every done/illegal pulse; checks writeback and flags one cycle later
    initial begin
        bit pend, pfl, pz, pn;
        logic [7:0] pv;
        exp_t e;
        chk_t c;
        pend = 0;
        pfl = 0;
        pz = 0;
        pn = 0;
        pv = 0;
        dbg_addr = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("dbg_read", dbg_data, pv);
                if (pfl) begin
                    chk("flag_z", flag_z, pz);
                    chk("flag_n", flag_n, pn);
                end
                pend = 0;
            end
            if (done || illegal) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {done, illegal}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {done, illegal}, e.ill ? 2'b01 : 2'b10);
                    chk("pulse_cycle", cyc, e.at);
                    if (e.ill) begin
                        chk("ill_flag_z", flag_z, e.z);
                        chk("ill_flag_n", flag_n, e.n);
                    end else begin
                        dbg_addr = e.rd;
                        pv = e.val;
                        pz = e.z;
                        pn = e.n;
                        pfl = 1;
                        pend = 1;
                    end
                end
            end else if (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                dbg_addr = c.a;
                pv = c.v;
                pfl = 0;
                pend = 1;
            end
        end
    end

    task automatic step(input bit l, input logic [1:0] a, input logic [7:0] d);
        int c;
        c = cyc;
        ld_en = l;
        ld_addr = a;
        ld_data = d;
        instr_valid = 0;
        @(posedge clk);
        // loads to the in-flight destination are overwritten (or dropped) by its writeback
        if (l && !(c <= g_end && a == g_rd)) m[a] = d;
        @(negedge clk);
        ld_en = 0;
    endtask

    task automatic issue(input logic [7:0] ins, output int waits);
        int c;
        logic [7:0] a, b, r;
        logic [1:0] rd, rs;
        exp_t e;
        ld_en = 0;
        instr = ins;
        instr_valid = 1;
        waits = 0;
        while (!instr_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (!instr_ready) chk("ready_timeout", instr_ready, 1);
        c = cyc;
        rd = ins[3:2];
        rs = ins[1:0];
        if (ins[7:6] == 2'b01) begin
            a = m[rd];
            b = m[rs];
            case (ins[5:4])
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = a ^ b;
                default: r = a & ~b;
            endcase
            m[rd] = r;
            mz = r == 0;
            mn = r[7];
            g_end = c + 3;
            g_rd = rd;
            e.ill = 0; e.rd = rd; e.val = r; e.at = c + 3;
        end else begin
            e.ill = 1; e.rd = 0; e.val = 0; e.at = c + 1;
        end
        e.z = mz;
        e.n = mn;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic dump();
        chk_t c;
        for (int i = 0; i < 4; i++) begin
            c.a = 2'(i);
            c.v = m[i];
            chk_q.push_back(c);
        end
        idle(6);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 0;
        mz = 0;
        mn = 0;
        g_end = -10;
        exp_q.delete();
    endtask

    task automatic reset_checks();
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_flags", {flag_z, flag_n}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_s", alu_s, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        logic [1:0] cls;
        rst = 1;
        instr_valid = 0;
        instr = 0;
        ld_en = 0;
        ld_addr = 0;
        ld_data = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        reset_checks();
        dump();

        step(1, 0, 8'hF0);
        step(1, 1, 8'h3C);
        issue(8'h41, w);
        idle(4);
        step(1, 2, 8'h5A);
        issue(8'h6A, w);
        idle(4);
        step(1, 0, 8'hF0);
        issue(8'h51, w);
        idle(4);
        step(1, 0, 8'hF0);
        issue(8'h71, w);
        idle(4);

        issue(8'h01, w);
        chk("ready_in_err", instr_ready, 0);
        step(0, 0, 0);
        chk("ready_after_err", instr_ready, 1);
        dump();

        issue(8'h51, w);
        issue(8'h6A, w);
        chk("b2b_gap", w, 3);
        step(0, 0, 0);
        step(1, 1, 8'h11);
        step(1, 2, 8'h77);
        idle(2);
        dump();

        step(1, 0, 8'hF0);
        issue(8'h51, w);
        idle(4);
        issue(8'h41, w);
        step(0, 0, 0);
        rst = 1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 0;
        reset_checks();
        idle(4);
        dump();

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1, 2'($urandom), 8'($urandom));
            end else begin
                cls = $urandom_range(0, 3) != 0 ? 2'b01 : 2'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(2, 3));
                issue({cls, 6'($urandom)}, w);
                for (int k = 0; k < (cls == 2'b01 ? 3 : 1); k++)
                    step($urandom_range(0, 1) == 1, 2'($urandom), 8'($urandom));
            end
            if (it % 20 == 19) dump();
        end
        idle(8);
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
